// File: rtl/fanout_broadcast.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fanout_broadcast                                                 |
// | Brief    : Broadcasts one upstream token to a selectable set of consumers,  |
// |            tracking per-destination delivery with pending bits.             |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fanout_broadcast #(
   parameter int NUM_OUT    = 6,
   parameter int DATA_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic [NUM_OUT-1:0]    enable,
   input  logic [NUM_OUT-1:0]    sel_mask,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]    out_valid,
   input  logic [NUM_OUT-1:0]    out_ready,
   output logic                  busy,
   output logic [15:0]           drop_count
);

   localparam logic [15:0] c_drop_max = 16'hFFFF;

   logic                  r_full;
   logic [NUM_OUT-1:0]    r_pend;
   logic [DATA_WIDTH-1:0] r_data;
   logic [15:0]           r_drop_count;

   logic [NUM_OUT-1:0]    w_active;
   logic                  w_any_active;
   logic                  w_done;
   logic                  w_in_fire;
   logic                  w_load;
   logic                  w_drop;
   logic [NUM_OUT-1:0]    w_out_fire;

   assign w_active     = enable & sel_mask;
   assign w_any_active = |w_active;

   // Done means every still-pending destination handshakes this very cycle.
   assign w_done       = r_full & ((r_pend & ~out_ready) == '0);

   assign in_ready     = rst_n & clk_en & ~flush & (~r_full | w_done);
   assign w_in_fire    = in_valid & in_ready;
   assign w_load       = w_in_fire & w_any_active;
   assign w_drop       = w_in_fire & ~w_any_active;

   assign out_valid    = r_pend & {NUM_OUT{clk_en & r_full}};
   assign w_out_fire   = out_valid & out_ready;
   assign out_data     = r_data;
   assign busy         = r_full;
   assign drop_count   = r_drop_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full       <= 1'b0;
         r_pend       <= '0;
         r_data       <= '0;
         r_drop_count <= '0;
      end else if (clk_en) begin
         if (flush) begin
            r_full       <= 1'b0;
            r_pend       <= '0;
            r_drop_count <= '0;
         end else begin
            // A load on the completion edge replaces the old token outright.
            if (w_load) begin
               r_data <= in_data;
               r_pend <= w_active;
               r_full <= 1'b1;
            end else if (w_done) begin
               r_pend <= '0;
               r_full <= 1'b0;
            end else begin
               r_pend <= r_pend & ~w_out_fire;
            end

            if (w_drop && (r_drop_count != c_drop_max)) begin
               r_drop_count <= r_drop_count + 16'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fanout_broadcast.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fanout_broadcast                                              |
// | Brief    : Directed and random checks of fanout_broadcast against per-      |
// |            destination delivery queues.                                     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_fanout_broadcast;

   localparam int N = 6;
   localparam int W = 17;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clk_en = 1'b0;
   logic         flush = 1'b0;
   logic [N-1:0] enable = '0;
   logic [N-1:0] sel_mask = '0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic [N-1:0] out_valid;
   logic [N-1:0] out_ready = '0;
   logic         busy;
   logic [15:0]  drop_count;

   fanout_broadcast #(.NUM_OUT(N), .DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .flush      (flush),
      .enable     (enable),
      .sel_mask   (sel_mask),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Each destination owns a queue of tokens it has yet to receive.
   logic [W-1:0] mq [N][$];
   int           mdrop = 0;
   int           deliv [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) mq[i].delete();
      mdrop = 0;
   endtask

   // Inputs are set before the call; outputs are compared mid-cycle, then the
   // reference queues advance according to the handshakes the rules imply.
   task automatic step();
      logic         exp_rdy;
      logic [N-1:0] exp_v;
      logic [N-1:0] act;
      logic         anyq;
      #2;
      exp_v   = '0;
      anyq    = 1'b0;
      exp_rdy = clk_en & ~flush & rst_n;
      for (int i = 0; i < N; i++) begin
         if (mq[i].size() != 0) begin
            anyq = 1'b1;
            if (clk_en) exp_v[i] = 1'b1;
            if (!out_ready[i]) exp_rdy = 1'b0;
         end
      end
      check("in_ready",   32'(in_ready),   32'(exp_rdy));
      check("out_valid",  32'(out_valid),  32'(exp_v));
      check("busy",       32'(busy),       32'(anyq));
      check("drop_count", 32'(drop_count), 32'(mdrop));
      for (int i = 0; i < N; i++) begin
         if (exp_v[i]) check("out_data", 32'(out_data), 32'(mq[i][0]));
      end
      if (clk_en && rst_n) begin
         if (flush) begin
            model_clear();
         end else begin
            for (int i = 0; i < N; i++) begin
               if (exp_v[i] && out_ready[i]) begin
                  mq[i].delete(0);
                  deliv[i]++;
               end
            end
            if (in_valid && exp_rdy) begin
               act = enable & sel_mask;
               if (act == '0) begin
                  if (mdrop < 65535) mdrop++;
               end else begin
                  for (int i = 0; i < N; i++) if (act[i]) mq[i].push_back(in_data);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) deliv[i] = 0;

      // Reset state
      #1;
      check("rst_in_ready",  32'(in_ready),   32'd0);
      check("rst_out_valid", 32'(out_valid),  32'd0);
      check("rst_out_data",  32'(out_data),   32'd0);
      check("rst_busy",      32'(busy),       32'd0);
      check("rst_drop",      32'(drop_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      clk_en = 1'b1;
      step();

      // Streaming to destinations 0..2, all ready
      enable = 6'b111111; sel_mask = 6'b000111; out_ready = 6'b111111;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_data = 17'(k);
         step();
      end
      in_valid = 1'b0;
      step();
      for (int i = 0; i < N; i++) check("t1_deliv", 32'(deliv[i]), (i < 3) ? 32'd10 : 32'd0);

      // Destination 1 stalls for three cycles
      sel_mask = 6'b000011; out_ready = 6'b000001;
      in_valid = 1'b1; in_data = 17'h1A5;
      step();
      in_data = 17'h0F0;
      step();
      check("t2_pend", 32'(out_valid), 32'h02);
      step();
      step();
      out_ready = 6'b000011;
      step();
      in_valid = 1'b0;
      check("t2_next", 32'(out_valid), 32'h03);
      check("t2_next_data", 32'(out_data), 32'h0F0);
      step();

      // Everything dropped while nothing is selected
      out_ready = 6'b111111; sel_mask = 6'b000000; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 17'(k + 32);
         step();
      end
      in_valid = 1'b0;
      check("t3_drop", 32'(drop_count), 32'd5);
      check("t3_busy", 32'(busy), 32'd0);

      // Active set is latched at load
      out_ready = 6'b000000; sel_mask = 6'b100001; in_valid = 1'b1; in_data = 17'h055;
      step();
      in_valid = 1'b0; sel_mask = 6'b000000;
      step();
      step();
      check("t4_sticky", 32'(out_valid), 32'h21);
      out_ready = 6'b111111;
      step();
      check("t4_busy", 32'(busy), 32'd0);

      // Flush, then asynchronous reset mid-token
      out_ready = 6'b000000; sel_mask = 6'b000101; in_valid = 1'b1; in_data = 17'h1234;
      step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("t5_flush_busy",  32'(busy),       32'd0);
      check("t5_flush_valid", 32'(out_valid),  32'd0);
      check("t5_flush_drop",  32'(drop_count), 32'd0);
      in_valid = 1'b1; in_data = 17'h0ABC;
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      check("t5_rst_busy",  32'(busy),      32'd0);
      check("t5_rst_ready", 32'(in_ready),  32'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Clock enable low freezes everything
      out_ready = 6'b000000; sel_mask = 6'b001001; in_valid = 1'b1; in_data = 17'h1F0F;
      step();
      in_valid = 1'b0; clk_en = 1'b0; out_ready = 6'b111111;
      for (int k = 0; k < 4; k++) step();
      check("t6_hold_busy", 32'(busy), 32'd1);
      clk_en = 1'b1;
      step();
      check("t6_done_busy", 32'(busy), 32'd0);

      // Random traffic
      enable = 6'b111111;
      for (int k = 0; k < 400; k++) begin
         enable    = 6'($urandom) | 6'($urandom);
         sel_mask  = 6'($urandom) | 6'($urandom);
         out_ready = 6'($urandom) | 6'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 17'($urandom);
         clk_en    = ($urandom_range(0, 9) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         step();
      end
      flush = 1'b0; clk_en = 1'b1; in_valid = 1'b0; out_ready = 6'b111111;
      step();
      check("final_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
